// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 frame receiver.
//   ps2_state_e         receiver FSM state encoding
//   PS2_FRAME_BITS      start + 8 data + parity + stop
//   PS2_DATA_BITS       data bits per frame
//   PS2_TIMEOUT_DEFAULT default mid-frame inactivity limit in clk cycles
//   PS2_TO_WIDTH        width of the inactivity counter
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam int PS2_FRAME_BITS      = 11;
    localparam int PS2_DATA_BITS       = PS2_FRAME_BITS - 3;
    localparam int PS2_TIMEOUT_DEFAULT = 50000;
    localparam int PS2_TO_WIDTH        = 17;

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: brings the raw PS/2 clock/data pair into the clk domain and
// flags falling edges of the PS/2 clock.
//   clk, rst    system clock, async active-high reset
//   ps2_clk_i   raw PS/2 clock line (idle high)
//   ps2_data_i  raw PS/2 data line (idle high)
//   fall_o      one-cycle pulse on a synchronized PS/2 clock falling edge
//   data_o      synchronized PS/2 data
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic fall_o,
    output logic data_o
);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;

    // Flops reset to the idle-high line level so leaving reset never looks
    // like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall_o = clk_prev_q & ~clk_sync_q;
    assign data_o = data_sync_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: receives 11-bit PS/2 device frames and writes good bytes to a
// downstream FIFO.
//   clk, rst      system clock, async active-high reset
//   ps2_clk       raw PS/2 clock, ps2_data raw PS/2 data
//   fifo_full     downstream FIFO full flag
//   fifo_data     last received byte (held between writes)
//   fifo_wr_en    one-cycle write strobe, fifo_wr_cs mirrors it
//   frame_err     one-cycle pulse on parity, stop-bit or timeout error
//   overflow_cnt  saturating count of good frames dropped on fifo_full
//   busy          high while a frame is in progress
//
// state  | meaning
// IDLE   | waiting for a start bit (falling edge with data low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | waiting for the stop bit, then judging the frame
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_wr_cs,
    output logic                  fifo_wr_en,
    output logic                  frame_err,
    output logic [7:0]            overflow_cnt,
    output logic                  busy
);

    localparam logic [PS2_TO_WIDTH-1:0] TO_LAST  = PS2_TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [PS2_TO_WIDTH-1:0] TO_ONE   = PS2_TO_WIDTH'(1);
    localparam logic [2:0]              BIT_LAST = 3'(PS2_DATA_BITS - 1);

    logic fall, dat;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .fall_o     (fall),
        .data_o     (dat)
    );

    ps2_state_e              state_q,  state_d;
    logic [DATA_WIDTH-1:0]   shift_q,  shift_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic                    parity_q, parity_d;
    logic [PS2_TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
    logic                    wr_en_q,  wr_en_d;
    logic                    err_q,    err_d;
    logic [DATA_WIDTH-1:0]   data_q,   data_d;
    logic [7:0]              ovf_q,    ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            to_cnt_q  <= '0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            to_cnt_q  <= to_cnt_d;
            wr_en_q   <= wr_en_d;
            err_q     <= err_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        wr_en_d   = 1'b0;
        err_d     = 1'b0;
        data_d    = data_q;
        ovf_d     = ovf_q;
        to_cnt_d  = (state_q == ST_IDLE || fall) ? '0 : to_cnt_q + TO_ONE;

        case (state_q)
            ST_IDLE: begin
                // A falling edge with data high is line noise, not a start bit.
                if (fall && !dat) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d   = {dat, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_d = dat;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (dat && (^{shift_q, parity_q})) begin
                        if (fifo_full) begin
                            ovf_d = (ovf_q == 8'hFF) ? ovf_q : ovf_q + 8'd1;
                        end else begin
                            wr_en_d = 1'b1;
                            data_d  = shift_q;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An edge in the same cycle keeps the frame alive.
        if (state_q != ST_IDLE && !fall && to_cnt_q == TO_LAST) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            err_d     = 1'b1;
        end
    end

    assign fifo_data    = data_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_cs   = wr_en_q;
    assign frame_err    = err_q;
    assign overflow_cnt = ovf_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
module tb_ps2_frame_rx;

    localparam int HALF = 6;
    localparam int TO   = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       fifo_full = 1'b0;
    logic [7:0] fifo_data;
    logic       fifo_wr_cs, fifo_wr_en, frame_err, busy;
    logic [7:0] overflow_cnt;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TO), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .fifo_full    (fifo_full),
        .fifo_data    (fifo_data),
        .fifo_wr_cs   (fifo_wr_cs),
        .fifo_wr_en   (fifo_wr_en),
        .frame_err    (frame_err),
        .overflow_cnt (overflow_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  ovf_model   = 0;
    int  writes_seen = 0;
    int  errs_seen   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Odd-parity bit for a byte: makes the 9-bit XOR equal to 1.
    function automatic bit par_for(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Every strobe or error pulse must match the next expected event in order.
    always @(negedge clk) begin : cmp
        ev_t ev;
        if (!rst) begin
            if (fifo_wr_en === 1'b1 || fifo_wr_cs === 1'b1)
                check("wr_cs_eq_wr_en", {31'd0, fifo_wr_cs}, {31'd0, fifo_wr_en});
            if (fifo_wr_en === 1'b1) writes_seen++;
            if (frame_err === 1'b1) errs_seen++;
            if (fifo_wr_en === 1'b1 || frame_err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: wr_en=%0b err=%0b data=%0h with nothing expected",
                             fifo_wr_en, frame_err, fifo_data);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_is_err", {31'd0, frame_err}, {31'd0, ev.is_err});
                    check("event_is_wr", {31'd0, fifo_wr_en}, {31'd0, !ev.is_err});
                    if (!ev.is_err) check("event_data", {24'd0, fifo_data}, {24'd0, ev.data});
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input bit b);
        ps2_data = b;
        wait_clks(HALF);
        ps2_clk = 1'b0;
        wait_clks(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit stop);
        bit good;
        good = stop && (^{d, par});
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        if (good) begin
            if (fifo_full) ovf_model++;
            else exp_q.push_back('{1'b0, d});
        end else begin
            exp_q.push_back('{1'b1, 8'h00});
        end
        ps2_bit(stop);
        ps2_data = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] d);
        send_frame(d, par_for(d), 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            wait_clks(1);
            n++;
        end
        wait_clks(4);
        check(name, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #(10 * 90000);
        fails++;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin : main
        int t0;
        int delay;
        bit seen;

        // Model pinned against hand-computed parities.
        check("model_par_1C", {31'd0, par_for(8'h1C)}, 32'd0);
        check("model_par_F0", {31'd0, par_for(8'hF0)}, 32'd1);

        wait_clks(3);
        #4;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_wr_en", {31'd0, fifo_wr_en}, 0);
        check("rst_err", {31'd0, frame_err}, 0);
        check("rst_data", {24'd0, fifo_data}, 0);
        check("rst_ovf", {24'd0, overflow_cnt}, 0);
        rst = 1'b0;
        wait_clks(3);

        // Good frame 0x1C, parity 0.
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("drain_good");
        check("good_data", {24'd0, fifo_data}, 32'h1C);
        check("good_writes", writes_seen, 1);
        check("good_errs", errs_seen, 0);
        check("good_busy", {31'd0, busy}, 0);

        // Parity error: data must hold.
        send_frame(8'h1C, 1'b1, 1'b1);
        drain("drain_parity");
        check("parity_errs", errs_seen, 1);
        check("parity_hold", {24'd0, fifo_data}, 32'h1C);

        // Stop-bit error.
        send_frame(8'hA5, par_for(8'hA5), 1'b0);
        drain("drain_stop");
        check("stop_errs", errs_seen, 2);

        // Falling edge with data high in IDLE: no frame, no error.
        ps2_bit(1'b1);
        wait_clks(6);
        check("glitch_busy", {31'd0, busy}, 0);
        check("glitch_errs", errs_seen, 2);

        // Back-to-back frames.
        good_frame(8'hE0);
        good_frame(8'hF0);
        good_frame(8'h75);
        drain("drain_b2b");
        check("b2b_writes", writes_seen, 4);
        check("b2b_last", {24'd0, fifo_data}, 32'h75);

        // Timeout after 4 data bits.
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        ps2_data = 1'b0;
        wait_clks(HALF);
        ps2_clk = 1'b0;
        t0 = cyc;
        exp_q.push_back('{1'b1, 8'h00});
        seen = 1'b0;
        delay = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (cyc - t0 == HALF) ps2_clk = 1'b1;
            if (cyc - t0 == 20) check("timeout_busy_mid", {31'd0, busy}, 1);
            if (frame_err === 1'b1) begin
                seen = 1'b1;
                delay = cyc - t0;
            end
        end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        tests++;
        if (!seen || delay < TO || delay > TO + 6) begin
            fails++;
            $display("FAIL timeout_delay: got %0d cycles (seen=%0b) required %0d..%0d", delay, seen, TO, TO + 6);
        end
        wait_clks(2);
        check("timeout_busy", {31'd0, busy}, 0);
        good_frame(8'hF0);
        drain("drain_after_to");
        check("after_to_data", {24'd0, fifo_data}, 32'hF0);

        // Reset mid-frame after 5 data bits of 0x29.
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i == 0 || i == 3);
        check("midrst_busy_before", {31'd0, busy}, 1);
        rst = 1'b1;
        ps2_data = 1'b1;
        wait_clks(3);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_data", {24'd0, fifo_data}, 0);
        rst = 1'b0;
        wait_clks(30);
        check("midrst_no_event", writes_seen + errs_seen, 8);
        good_frame(8'h29);
        drain("drain_after_rst");
        check("after_rst_data", {24'd0, fifo_data}, 32'h29);

        // Full FIFO: drops counted, saturating.
        fifo_full = 1'b1;
        good_frame(8'h11);
        good_frame(8'h22);
        good_frame(8'h33);
        wait_clks(10);
        check("ovf_3", {24'd0, overflow_cnt}, 32'd3);
        check("ovf_model_3", {24'd0, overflow_cnt}, ovf_model);
        for (int i = 0; i < 256; i++) good_frame(8'(i));
        wait_clks(10);
        check("ovf_sat", {24'd0, overflow_cnt}, 32'd255);
        check("ovf_model_sat", {24'd0, overflow_cnt}, (ovf_model > 255) ? 255 : ovf_model);
        check("ovf_writes", writes_seen, 6);
        check("ovf_hold", {24'd0, fifo_data}, 32'h29);
        fifo_full = 1'b0;

        drain("drain_final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
